// File: rtl/vend_pkg.sv
// Shared vending definitions: change-dispenser state encoding, coin values, fault codes.
package vend_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJECT,
      S_WAIT,
      S_DONE,
      S_FAULT
   } cd_state_t;

   // coin values in units of 5
   localparam int COIN5_UNITS  = 1;
   localparam int COIN10_UNITS = 2;

   // fault_code values
   localparam logic FC_JAM   = 1'b0;
   localparam logic FC_SHORT = 1'b1;

endpackage

// File: rtl/cd_timeout_timer.sv
// Clear/enable cycle counter; 'expired' flags that the count has reached TIMEOUT-1.
module cd_timeout_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   assign expired = (count == LAST);

   // count while enabled; clear has priority; hold at the terminal value
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && !expired)
         count <= count + W'(1);
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an owed amount through 10- and 5-unit hoppers one coin at a
// time, waiting for the hopper coin sensor after each eject. Reports done, jam or short.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             empty10,
   input  logic             empty5,
   input  logic             coin_sense,
   output logic             eject10,
   output logic             eject5,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic             fault_code
);

   localparam logic [AMT_W-1:0] U10 = AMT_W'(COIN10_UNITS);
   localparam logic [AMT_W-1:0] U5  = AMT_W'(COIN5_UNITS);

   cd_state_t        state;
   logic [AMT_W-1:0] remaining;
   logic             coin10;     // coin in flight is a 10-unit coin
   logic             expired;

   // timer restarts on each eject and runs only while waiting for the sensor
   cd_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == S_EJECT),
      .en      (state == S_WAIT),
      .expired (expired)
   );

   // payout FSM; every output is registered alongside the state it belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         remaining  <= '0;
         coin10     <= 1'b0;
         eject10    <= 1'b0;
         eject5     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 1'b0;
      end else begin
         eject10 <= 1'b0;
         eject5  <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  remaining  <= amount;
                  coin10     <= 1'b0;
                  fault      <= 1'b0;
                  fault_code <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_SELECT;
               end
            end
            S_SELECT: begin
               // largest coin first, but never a 10 when only 5 is owed
               if (remaining == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (remaining >= U10 && !empty10) begin
                  coin10  <= 1'b1;
                  eject10 <= 1'b1;
                  state   <= S_EJECT;
               end else if (!empty5) begin
                  coin10 <= 1'b0;
                  eject5 <= 1'b1;
                  state  <= S_EJECT;
               end else begin
                  fault      <= 1'b1;
                  fault_code <= FC_SHORT;
                  state      <= S_FAULT;
               end
            end
            S_EJECT: state <= S_WAIT;
            S_WAIT: begin
               // a coin arriving on the timeout cycle still counts
               if (coin_sense) begin
                  remaining <= remaining - (coin10 ? U10 : U5);
                  state     <= S_SELECT;
               end else if (expired) begin
                  fault      <= 1'b1;
                  fault_code <= FC_JAM;
                  state      <= S_FAULT;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_FAULT: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser: a timeline model of the payout
// rules queues expected events, a monitor pops and compares whatever the DUT emits.
module tb_change_dispenser;

   localparam int AMT_W   = 4;
   localparam int TIMEOUT = 15;
   localparam int NOJAM   = 99;

   logic             clk = 1'b0;
   logic             rst;
   logic             req;
   logic [AMT_W-1:0] amount;
   logic             empty10, empty5, coin_sense;
   logic             eject10, eject5, busy, done, fault, fault_code;

   change_dispenser #(.AMT_W(AMT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .amount     (amount),
      .empty10    (empty10),
      .empty5     (empty5),
      .coin_sense (coin_sense),
      .eject10    (eject10),
      .eject5     (eject5),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // event kinds: 0 eject10, 1 eject5, 2 done, 3 fault (code checked)
   typedef struct {
      int kind;
      int code;
      int at;
   } ev_t;
   ev_t exp_q[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req_v, cyc);
      end
   endtask

   // hopper model: answers each eject after sense_d cycles unless that eject is jammed
   int sense_d  = 1;
   int jam_at   = -1;
   int stray_at = -1;
   int ej_total = 0;
   int sense_at = -1;

   initial begin
      coin_sense = 1'b0;
      forever begin
         @(negedge clk);
         coin_sense = 1'b0;
         if (rst) begin
            sense_at = -1;
         end else begin
            if (stray_at == cyc) coin_sense = 1'b1;
            if (sense_at == cyc) begin
               coin_sense = 1'b1;
               sense_at   = -1;
            end
            if (eject10 || eject5) begin
               if (ej_total != jam_at) sense_at = cyc + sense_d;
               ej_total++;
            end
         end
      end
   end

   // monitor: every DUT-presented event must match the head of the expected queue
   task automatic match(input int kind, input int code);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc, e.at);
         if (kind == 3) chk("fault_code", code, e.code);
      end
   endtask

   initial begin
      logic fault_q = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (eject10) match(0, 0);
            if (eject5) match(1, 0);
            if (done) match(2, 0);
            if (fault && !fault_q) match(3, int'(fault_code));
            fault_q = fault;
         end else begin
            fault_q = 1'b0;
         end
      end
   end

   // reference model: greedy coin choice with fixed stock, timed from the payout rules
   task automatic push_model(input int n, input int amt, input bit e10, input bit e5,
                             input int d, input int jidx);
      int t = n + 1;   // cycle spent choosing a coin
      int rem = amt;
      int k = 0;
      int kind, units, e;
      forever begin
         if (rem == 0) begin
            exp_q.push_back('{2, 0, t + 1});
            return;
         end
         if (rem >= 2 && !e10) begin
            kind = 0; units = 2;
         end else if (!e5) begin
            kind = 1; units = 1;
         end else begin
            exp_q.push_back('{3, 1, t + 1});
            return;
         end
         e = t + 1;
         exp_q.push_back('{kind, 0, e});
         if (k == jidx) begin
            exp_q.push_back('{3, 0, e + TIMEOUT + 1});
            return;
         end
         rem -= units;
         t = e + d + 1;
         k++;
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_eject10"}, int'(eject10), 0);
      chk({name, "_eject5"}, int'(eject5), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_done"}, int'(done), 0);
      chk({name, "_fault"}, int'(fault), 0);
      chk({name, "_fault_code"}, int'(fault_code), 0);
   endtask

   task automatic wait_eject(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (eject10 || eject5) begin
            ok = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL eject_wait: got no eject in 50 cycles, required one");
   endtask

   // one transaction; mode 0 normal, 1 duplicate req during WAIT, 2 reset during WAIT
   task automatic run_txn(input int amt, input bit e10, input bit e5, input int d,
                          input int jidx, input int mode);
      int n, last;
      bit ok, end_fault;
      int end_code;
      @(negedge clk);
      empty10 = e10;
      empty5  = e5;
      sense_d = d;
      jam_at  = ej_total + jidx;
      amount  = AMT_W'(amt);
      req     = 1'b1;
      n       = cyc;
      push_model(n, amt, e10, e5, d, jidx);
      last      = exp_q[exp_q.size()-1].at;
      end_fault = (exp_q[exp_q.size()-1].kind == 3);
      end_code  = exp_q[exp_q.size()-1].code;
      @(negedge clk);
      req = 1'b0;
      chk("busy_after_req", int'(busy), 1);
      chk("fault_cleared_by_req", int'(fault), 0);
      if (mode == 1) begin
         wait_eject(ok);
         @(negedge clk);
         amount = AMT_W'(amt ^ 5);
         req    = 1'b1;
         @(negedge clk);
         req = 1'b0;
      end else if (mode == 2) begin
         wait_eject(ok);
         @(negedge clk);
         rst = 1'b1;
         exp_q.delete();
         #1 chk_all_zero("reset_async");
         @(negedge clk);
         chk_all_zero("reset_next_cycle");
         rst = 1'b0;
         @(negedge clk);
         chk_all_zero("after_reset_release");
         return;
      end
      for (int i = 0; i < 400; i++) begin
         if (cyc > last) break;
         @(negedge clk);
         if (cyc == last) chk("busy_at_last_event", int'(busy), 1);
      end
      if (cyc == last) @(negedge clk);
      chk("busy_after_end", int'(busy), 0);
      chk("fault_sticky", int'(fault), int'(end_fault));
      if (end_fault) chk("fault_code_sticky", int'(fault_code), end_code);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL events_left: got %0d pending events, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst     = 1'b1;
      req     = 1'b0;
      amount  = '0;
      empty10 = 1'b0;
      empty5  = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset_state");
      rst = 1'b0;
      @(negedge clk);

      // directed cases
      run_txn(3, 0, 0, 1, NOJAM, 0);   // 10 then 5
      run_txn(3, 0, 0, 2, NOJAM, 0);   // slower sensor
      run_txn(3, 1, 0, 1, NOJAM, 0);   // 10 hopper empty: three 5s
      run_txn(0, 0, 0, 1, NOJAM, 0);   // nothing owed
      run_txn(2, 0, 0, 1, 0, 0);       // jam on the first coin
      run_txn(1, 0, 0, 1, NOJAM, 0);   // new req clears the jam fault
      run_txn(1, 0, 1, 1, NOJAM, 0);   // 5 owed, 5 hopper empty
      run_txn(3, 0, 1, 1, NOJAM, 0);   // 10 paid, then short on the 5
      run_txn(5, 1, 1, 1, NOJAM, 0);   // both empty
      run_txn(15, 0, 0, TIMEOUT, NOJAM, 0); // sensor on the timeout cycle wins
      run_txn(3, 0, 0, 3, NOJAM, 1);   // second req during WAIT ignored
      run_txn(3, 0, 0, 3, NOJAM, 2);   // reset during WAIT
      run_txn(1, 0, 0, 1, NOJAM, 0);   // normal after reset

      // stray sensor pulse while idle must not disturb the next payout
      stray_at = cyc + 1;
      repeat (3) @(negedge clk);
      run_txn(4, 0, 0, 1, NOJAM, 0);

      // randomized transactions
      for (int i = 0; i < 40; i++) begin
         int amt, d, jidx;
         bit e10, e5;
         amt  = $urandom_range(0, 15);
         e10  = ($urandom_range(0, 3) == 0);
         e5   = ($urandom_range(0, 3) == 0);
         d    = $urandom_range(1, 4);
         jidx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : NOJAM;
         if ($urandom_range(0, 4) == 0) begin
            stray_at = cyc + 1;
            repeat (2) @(negedge clk);
         end
         run_txn(amt, e10, e5, d, jidx, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
